// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: handshaked scheduler for one fully-connected layer.
// Sweeps input index per neuron, drives the MAC, then hands off each neuron.
module dense_layer_sequencer #(
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = 8,
  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  output logic          ready_o,
  input  logic          data_v_i,
  output logic [IW-1:0] in_addr_o,
  output logic [OW-1:0] neuron_o,
  output logic          mac_en_o,
  output logic          acc_clear_o,
  output logic          valid_o,
  output logic          last_o,
  input  logic          yumi_i
);

  typedef enum logic [1:0] {
    eIDLE,
    eMAC,
    eOUT
  } state_e;

  localparam logic [IW-1:0] IN_LAST  = IW'(INPUT_SIZE - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUTPUT_SIZE - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] in_addr_q, in_addr_d;
  logic [OW-1:0] neuron_q, neuron_d;

  // State and counter registers; reset wins over every input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= eIDLE;
      in_addr_q <= '0;
      neuron_q  <= '0;
    end else begin
      state_q   <= state_d;
      in_addr_q <= in_addr_d;
      neuron_q  <= neuron_d;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_d     = state_q;
    in_addr_d   = in_addr_q;
    neuron_d    = neuron_q;
    ready_o     = 1'b0;
    mac_en_o    = 1'b0;
    acc_clear_o = 1'b0;
    valid_o     = 1'b0;
    last_o      = 1'b0;
    unique case (state_q)
      eIDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d   = eMAC;
          in_addr_d = '0;
          neuron_d  = '0;
        end
      end
      eMAC: begin
        mac_en_o    = data_v_i;
        acc_clear_o = data_v_i & (in_addr_q == '0);
        if (data_v_i) begin
          if (in_addr_q == IN_LAST) begin
            in_addr_d = '0;
            state_d   = eOUT;
          end else begin
            in_addr_d = in_addr_q + IW'(1);
          end
        end
      end
      eOUT: begin
        valid_o = 1'b1;
        last_o  = (neuron_q == OUT_LAST);
        if (yumi_i) begin
          if (neuron_q == OUT_LAST) begin
            neuron_d = '0;
            state_d  = eIDLE;
          end else begin
            neuron_d = neuron_q + OW'(1);
            state_d  = eMAC;
          end
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  assign in_addr_o = in_addr_q;
  assign neuron_o  = neuron_q;

endmodule
